// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the memory-stage request inputs, the pipeline control outputs and
// the data-bus signals of mem_access_unit.
//
// Handshake: once bus_req rises it stays high, with bus_addr / bus_be /
// bus_we / bus_wdata frozen, until the cycle in which bus_ack is sampled
// high (that cycle completes the transfer and bus_rdata is taken in it).
// bus_ack seen while bus_req is low is ignored.
//
// Modports:
//   master - the access unit: consumes the M-stage instruction and bus
//            responses, drives stall, the bus request and the load/exception results.
//   slave  - the environment: pipeline plus memory side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              valid;
    logic [31:0]       Instr_in;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       WriteData;
    logic              stall;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;
    logic [31:0]       load_data;
    logic              load_valid;
    logic              exc;
    logic [1:0]        exc_code;

    modport master (
        input  valid, Instr_in, MemAddr, WriteData, bus_ack, bus_rdata,
        output stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
               load_data, load_valid, exc, exc_code
    );

    modport slave (
        output valid, Instr_in, MemAddr, WriteData, bus_ack, bus_rdata,
        input  stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
               load_data, load_valid, exc, exc_code
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage load/store engine. Decodes the M-stage instruction, rejects
// misaligned accesses with an address exception in the same cycle, and runs
// aligned accesses over a req/ack data bus while stalling the pipeline.
// Loads are sign/zero extended; a bus that never answers is reported as a
// timeout exception after TIMEOUT wait cycles.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset    - synchronous, active-high
//   io       - mem_access_unit_if.master (instruction, bus, results)
//   dbgState - current FSM state (0 IDLE, 1 WAIT, 2 DONE)
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.master io,
    output logic [1:0]        dbgState
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } stateE;

    stateE state, nextState;

    // Decoded op: size 0 byte, 1 half, 2 word
    logic        isMemOp, opStore, opUnsigned;
    logic [1:0]  opSize;
    logic        misaligned, launch;
    logic [3:0]  newBe;
    logic [31:0] storeSrc, newWdata;

    logic [ADDR_W-1:0] addrReg;
    logic [3:0]        beReg;
    logic [31:0]       wdataReg, loadDataReg;
    logic              storeReg, unsignedReg, errReg;
    logic [1:0]        sizeReg;
    logic [CNT_W-1:0]  waitCnt;

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadExt;
    logic        timeoutHit;

    logic unusedInstrBits;
    assign unusedInstrBits = ^{io.Instr_in[25:21], io.Instr_in[15:0]};

    always_comb begin
        isMemOp    = 1'b1;
        opStore    = 1'b0;
        opUnsigned = 1'b0;
        opSize     = 2'd2;
        case (io.Instr_in[31:26])
            6'b100011: opSize = 2'd2;
            6'b100000: opSize = 2'd0;
            6'b100100: begin opSize = 2'd0; opUnsigned = 1'b1; end
            6'b100001: opSize = 2'd1;
            6'b100101: begin opSize = 2'd1; opUnsigned = 1'b1; end
            6'b101011: begin opSize = 2'd2; opStore = 1'b1; end
            6'b101000: begin opSize = 2'd0; opStore = 1'b1; end
            6'b101001: begin opSize = 2'd1; opStore = 1'b1; end
            default:   isMemOp = 1'b0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        newBe      = 4'b1111;
        newWdata   = 32'd0;
        // A store from r0 always writes zero, whatever was forwarded.
        storeSrc   = (io.Instr_in[20:16] == 5'd0) ? 32'd0 : io.WriteData;
        case (opSize)
            2'd0: begin
                newBe    = 4'b0001 << io.MemAddr[1:0];
                newWdata = {4{storeSrc[7:0]}};
            end
            2'd1: begin
                misaligned = io.MemAddr[0];
                newBe      = io.MemAddr[1] ? 4'b1100 : 4'b0011;
                newWdata   = {2{storeSrc[15:0]}};
            end
            default: begin
                misaligned = (io.MemAddr[1:0] != 2'b00);
                newWdata   = storeSrc;
            end
        endcase
        if (!opStore) begin
            newWdata = 32'd0;
        end
    end

    // Little-endian lane selection from the registered low address bits.
    always_comb begin
        case (addrReg[1:0])
            2'd0:    laneByte = io.bus_rdata[7:0];
            2'd1:    laneByte = io.bus_rdata[15:8];
            2'd2:    laneByte = io.bus_rdata[23:16];
            default: laneByte = io.bus_rdata[31:24];
        endcase
        laneHalf = addrReg[1] ? io.bus_rdata[31:16] : io.bus_rdata[15:0];
        case (sizeReg)
            2'd0:    loadExt = unsignedReg ? {24'd0, laneByte} : {{24{laneByte[7]}}, laneByte};
            2'd1:    loadExt = unsignedReg ? {16'd0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
            default: loadExt = io.bus_rdata;
        endcase
    end

    assign timeoutHit = (waitCnt == CNT_LAST);

    always_comb begin
        nextState     = state;
        launch        = 1'b0;
        io.stall      = 1'b0;
        io.bus_req    = 1'b0;
        io.load_valid = 1'b0;
        io.exc        = 1'b0;
        io.exc_code   = 2'd0;
        case (state)
            S_IDLE: begin
                if (io.valid && isMemOp && !reset) begin
                    if (misaligned) begin
                        io.exc      = 1'b1;
                        io.exc_code = opStore ? 2'd2 : 2'd1;
                    end else begin
                        io.stall  = 1'b1;
                        launch    = 1'b1;
                        nextState = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                io.stall   = 1'b1;
                io.bus_req = 1'b1;
                // Ack wins over a simultaneous timeout.
                if (io.bus_ack || timeoutHit) begin
                    nextState = S_DONE;
                end
            end
            S_DONE: begin
                // The instruction still in M is the one just finished; the
                // pipeline advances past it at the end of this cycle.
                nextState = S_IDLE;
                if (errReg) begin
                    io.exc      = 1'b1;
                    io.exc_code = 2'd3;
                end else if (!storeReg) begin
                    io.load_valid = 1'b1;
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            waitCnt     <= '0;
            errReg      <= 1'b0;
            addrReg     <= '0;
            beReg       <= '0;
            wdataReg    <= '0;
            storeReg    <= 1'b0;
            sizeReg     <= '0;
            unsignedReg <= 1'b0;
            loadDataReg <= '0;
        end else begin
            state <= nextState;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        addrReg     <= io.MemAddr;
                        beReg       <= newBe;
                        wdataReg    <= newWdata;
                        storeReg    <= opStore;
                        sizeReg     <= opSize;
                        unsignedReg <= opUnsigned;
                        waitCnt     <= '0;
                        errReg      <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (io.bus_ack) begin
                        if (!storeReg) begin
                            loadDataReg <= loadExt;
                        end
                    end else if (timeoutHit) begin
                        errReg <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.bus_addr  = {addrReg[ADDR_W-1:2], 2'b00};
    assign io.bus_be    = beReg;
    assign io.bus_wdata = wdataReg;
    assign io.bus_we    = (state == S_WAIT) && storeReg;
    assign io.load_data = loadDataReg;
    assign dbgState     = state;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 15;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbgState;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) io ();

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .io       (io),
        .dbgState (dbgState)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] lastLoad = 32'd0;

    int          stallCount, waitCount, lvCount;
    logic [3:0]  seenBe;
    logic [31:0] seenWdata, seenAddr;
    logic        seenWe;
    logic        launchExc, doneExc, doneLv;
    logic [1:0]  launchCode, doneCode;

    localparam logic [5:0] OP_LW = 6'b100011, OP_LB = 6'b100000, OP_LBU = 6'b100100,
                           OP_LH = 6'b100001, OP_LHU = 6'b100101, OP_SW = 6'b101011,
                           OP_SB = 6'b101000, OP_SH = 6'b101001, OP_ADDU = 6'b000000;

    // Reference: access size in bytes, alignment as a remainder, lanes by shifting.
    function automatic void model(input logic [5:0] opc, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [4:0] rt,
                                  input logic [31:0] rdata, output bit isMem,
                                  output bit isStore, output bit misal,
                                  output logic [3:0] be, output logic [31:0] wdata,
                                  output logic [31:0] ld);
        int size, shift, bits;
        bit sgn;
        logic [31:0] sd, v;
        isMem = 1; isStore = 0; sgn = 0; size = 4;
        case (opc)
            OP_LW:  size = 4;
            OP_LB:  begin size = 1; sgn = 1; end
            OP_LBU: size = 1;
            OP_LH:  begin size = 2; sgn = 1; end
            OP_LHU: size = 2;
            OP_SW:  begin size = 4; isStore = 1; end
            OP_SB:  begin size = 1; isStore = 1; end
            OP_SH:  begin size = 2; isStore = 1; end
            default: isMem = 0;
        endcase
        misal = isMem && ((int'(addr[1:0]) % size) != 0);
        shift = (size == 4) ? 0 : (int'(addr[1:0]) / size) * size * 8;
        be    = 4'((32'd1 << size) - 1) << (shift / 8);
        sd    = (rt == 5'd0) ? 32'd0 : wd;
        if (!isStore)       wdata = 32'd0;
        else if (size == 1) wdata = {24'd0, sd[7:0]} * 32'h0101_0101;
        else if (size == 2) wdata = {16'd0, sd[15:0]} * 32'h0001_0001;
        else                wdata = sd;
        bits = size * 8;
        if (size == 4) v = rdata;
        else           v = (rdata >> shift) & ((32'd1 << bits) - 32'd1);
        if (size != 4 && sgn && v[bits-1]) v = v - (32'd1 << bits);
        ld = v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        io.valid   = 1'b0;
        io.bus_ack = 1'($urandom_range(0, 1));
        #2;
        checkCount++;
        if ({io.stall, io.bus_req, io.exc, io.load_valid} !== 4'b0000 || dbgState !== 2'd0 ||
            io.load_data !== lastLoad) begin
            $display("FAIL idle: ctl=%b state=%0d load_data=%h required ctl=0000 state=0 load_data=%h",
                     {io.stall, io.bus_req, io.exc, io.load_valid}, dbgState, io.load_data, lastLoad);
        end else passCount++;
        step();
        io.bus_ack = 1'b0;
    endtask

    // One full instruction from M-stage presentation to completion.
    // ackAt: WAIT cycle (1-based) in which bus_ack is driven; 0 = never.
    task automatic run_op(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rt, input logic [31:0] rdata, input int ackAt,
                          input bit vld);
        bit isMem, isStore, misal, acked, err, ok;
        logic [3:0]  be;
        logic [31:0] wdata, ld, expLd;
        logic [4:0]  expVec;
        model(opc, addr, wd, rt, rdata, isMem, isStore, misal, be, wdata, ld);
        stallCount = 0; waitCount = 0; lvCount = 0;
        io.valid     = vld;
        io.Instr_in  = {opc, 5'($urandom_range(0, 31)), rt, 16'($urandom)};
        io.MemAddr   = addr;
        io.WriteData = wd;
        io.bus_rdata = rdata;
        io.bus_ack   = 1'b0;
        #2;
        if (!vld || !isMem) expVec = 5'b00000;
        else if (misal)     expVec = {2'b00, 1'b1, (isStore ? 2'd2 : 2'd1)};
        else                expVec = 5'b10000;
        launchExc = io.exc; launchCode = io.exc_code;
        if (io.stall) stallCount++;
        checkCount++;
        if ({io.stall, io.bus_req, io.exc, io.exc_code} !== expVec) begin
            $display("FAIL launch_ctl op=%b addr=%h: {stall,req,exc,code}=%b required %b",
                     opc, addr, {io.stall, io.bus_req, io.exc, io.exc_code}, expVec);
        end else passCount++;
        checkCount++;
        if (io.load_valid !== 1'b0 || io.load_data !== lastLoad) begin
            $display("FAIL launch_hold: load_valid=%b load_data=%h required 0 / %h",
                     io.load_valid, io.load_data, lastLoad);
        end else passCount++;
        step();
        if (!vld || !isMem || misal) return;

        acked = 0;
        for (int w = 1; w <= TIMEOUT && !acked; w++) begin
            io.bus_ack = (w == ackAt);
            #2;
            waitCount++;
            if (io.stall) stallCount++;
            seenBe = io.bus_be; seenWdata = io.bus_wdata; seenAddr = io.bus_addr; seenWe = io.bus_we;
            checkCount++;
            if ({io.stall, io.bus_req, io.bus_we, io.exc, io.load_valid} !== {1'b1, 1'b1, isStore, 2'b00} ||
                io.bus_addr !== {addr[31:2], 2'b00} || io.bus_be !== be) begin
                $display("FAIL wait_bus cyc=%0d: ctl=%b addr=%h be=%b required ctl=%b addr=%h be=%b",
                         w, {io.stall, io.bus_req, io.bus_we, io.exc, io.load_valid}, io.bus_addr,
                         io.bus_be, {1'b1, 1'b1, isStore, 2'b00}, {addr[31:2], 2'b00}, be);
            end else passCount++;
            if (isStore) begin
                checkCount++;
                if (io.bus_wdata !== wdata) begin
                    $display("FAIL wait_wdata: bus_wdata=%h required %h", io.bus_wdata, wdata);
                end else passCount++;
            end
            if (w == ackAt) begin
                acked = 1;
                if (!isStore) exp_q.push_back(ld);
            end
            step();
            io.bus_ack = 1'b0;
        end
        err = !acked;

        #2;
        doneExc = io.exc; doneCode = io.exc_code; doneLv = io.load_valid;
        if (io.load_valid) lvCount++;
        if (io.stall) stallCount++;
        checkCount++;
        if ({io.stall, io.bus_req, io.exc, io.exc_code, io.load_valid} !==
            {1'b0, 1'b0, err, (err ? 2'd3 : 2'd0), (!isStore && !err)} || dbgState !== 2'd2) begin
            $display("FAIL done_ctl: {stall,req,exc,code,lv}=%b state=%0d required %b state=2",
                     {io.stall, io.bus_req, io.exc, io.exc_code, io.load_valid}, dbgState,
                     {1'b0, 1'b0, err, (err ? 2'd3 : 2'd0), (!isStore && !err)});
        end else passCount++;
        checkCount++;
        ok = 1;
        if (io.load_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                ok = 0;
                $display("FAIL done_data: load_valid=1 with no load outstanding");
            end else begin
                expLd = exp_q.pop_front();
                lastLoad = expLd;
                if (io.load_data !== expLd) begin
                    ok = 0;
                    $display("FAIL done_data: load_data=%h required %h", io.load_data, expLd);
                end
            end
        end else if (io.load_data !== lastLoad) begin
            ok = 0;
            $display("FAIL done_hold: load_data=%h required %h", io.load_data, lastLoad);
        end
        if (ok) passCount++;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        io.valid = 1'b0; io.Instr_in = 32'd0; io.MemAddr = '0; io.WriteData = 32'd0;
        io.bus_ack = 1'b0; io.bus_rdata = 32'd0;
        step(); step(); step();
        #2;
        checkCount++;
        if ({io.stall, io.bus_req, io.bus_we, io.exc, io.exc_code, io.load_valid} !== 7'd0 ||
            io.load_data !== 32'd0 || dbgState !== 2'd0) begin
            $display("FAIL reset: ctl=%b load_data=%h state=%0d required all zero",
                     {io.stall, io.bus_req, io.bus_we, io.exc, io.exc_code, io.load_valid},
                     io.load_data, dbgState);
        end else passCount++;
        reset = 1'b0;
        lastLoad = 32'd0;
        step();
    endtask

    task automatic test_lb_signed();
        run_op(OP_LB, 32'h0000_1003, $urandom, 5'd3, 32'h80FF_FF00, 2, 1'b1);
        idle_cycle();
        checkCount++;
        if (stallCount !== 3 || lvCount !== 1 || io.load_data !== 32'hFFFF_FF80) begin
            $display("FAIL lb_directed: stall_cycles=%0d lv_cycles=%0d load_data=%h required 3 1 ffffff80",
                     stallCount, lvCount, io.load_data);
        end else passCount++;
    endtask

    task automatic test_store_half();
        run_op(OP_SH, 32'h0000_2002, 32'h1234_ABCD, 5'd5, 32'd0, 1, 1'b1);
        checkCount++;
        if (seenBe !== 4'b1100 || seenWdata !== 32'hABCD_ABCD || seenAddr !== 32'h0000_2000 ||
            seenWe !== 1'b1) begin
            $display("FAIL sh_directed: be=%b wdata=%h addr=%h we=%b required 1100 abcdabcd 00002000 1",
                     seenBe, seenWdata, seenAddr, seenWe);
        end else passCount++;
        idle_cycle();
    endtask

    task automatic test_misaligned();
        run_op(OP_LW, 32'h0000_0006, $urandom, 5'd7, $urandom, 1, 1'b1);
        checkCount++;
        if (launchExc !== 1'b1 || launchCode !== 2'd1 || stallCount !== 0) begin
            $display("FAIL adel: exc=%b code=%0d stall_cycles=%0d required 1 1 0",
                     launchExc, launchCode, stallCount);
        end else passCount++;
        run_op(OP_SW, 32'h0000_0005, $urandom, 5'd7, $urandom, 1, 1'b1);
        checkCount++;
        if (launchExc !== 1'b1 || launchCode !== 2'd2) begin
            $display("FAIL ades: exc=%b code=%0d required 1 2", launchExc, launchCode);
        end else passCount++;
        run_op(OP_LH, 32'h0000_0103, $urandom, 5'd7, $urandom, 1, 1'b1);
        run_op(OP_SB, 32'h0000_0103, $urandom, 5'd7, $urandom, 1, 1'b1);
        idle_cycle();
    endtask

    task automatic test_timeout();
        run_op(OP_LW, 32'h0000_0100, $urandom, 5'd2, $urandom, 0, 1'b1);
        checkCount++;
        if (waitCount !== 15 || doneExc !== 1'b1 || doneCode !== 2'd3 || doneLv !== 1'b0) begin
            $display("FAIL timeout: wait_cycles=%0d exc=%b code=%0d lv=%b required 15 1 3 0",
                     waitCount, doneExc, doneCode, doneLv);
        end else passCount++;
        idle_cycle();
        run_op(OP_LW, 32'h0000_0104, $urandom, 5'd2, 32'hCAFE_F00D, 15, 1'b1);
        checkCount++;
        if (waitCount !== 15 || doneExc !== 1'b0 || doneLv !== 1'b1 || lastLoad !== 32'hCAFE_F00D) begin
            $display("FAIL ack_at_limit: wait_cycles=%0d exc=%b lv=%b load=%h required 15 0 1 cafef00d",
                     waitCount, doneExc, doneLv, lastLoad);
        end else passCount++;
        idle_cycle();
    endtask

    task automatic test_reset_in_wait();
        io.valid = 1'b1; io.Instr_in = {OP_LW, 5'd1, 5'd9, 16'd0}; io.MemAddr = 32'h40;
        io.bus_rdata = 32'h1111_2222; io.bus_ack = 1'b0;
        step();              // launch cycle
        #2;
        checkCount++;
        if (io.bus_req !== 1'b1) $display("FAIL rst_wait_req: bus_req=%b required 1", io.bus_req);
        else passCount++;
        step();              // WAIT cycle 2 follows
        reset = 1'b1;
        step();
        reset = 1'b0; io.valid = 1'b0; io.bus_ack = 1'b1;
        lastLoad = 32'd0;
        for (int k = 0; k < 3; k++) begin
            #2;
            checkCount++;
            if ({io.bus_req, io.stall, io.load_valid, io.exc} !== 4'b0000 || io.load_data !== 32'd0 ||
                dbgState !== 2'd0) begin
                $display("FAIL rst_abandon k=%0d: {req,stall,lv,exc}=%b load_data=%h state=%0d required 0000 0 0",
                         k, {io.bus_req, io.stall, io.load_valid, io.exc}, io.load_data, dbgState);
            end else passCount++;
            step();
            io.bus_ack = (k == 0);
        end
        io.bus_ack = 1'b0;
    endtask

    task automatic test_noop_rt0();
        run_op(OP_SB, 32'h0000_3001, 32'hFFFF_FFFF, 5'd0, 32'd0, 1, 1'b1);
        checkCount++;
        if (seenWdata !== 32'd0 || seenBe !== 4'b0010) begin
            $display("FAIL sb_rt0: wdata=%h be=%b required 00000000 0010", seenWdata, seenBe);
        end else passCount++;
        run_op(OP_ADDU, 32'h0000_3000, $urandom, 5'd4, $urandom, 1, 1'b1);
        checkCount++;
        if (stallCount !== 0 || dbgState !== 2'd0) begin
            $display("FAIL addu_noop: stall_cycles=%0d state=%0d required 0 0", stallCount, dbgState);
        end else passCount++;
        run_op(OP_LW, 32'h0000_3000, $urandom, 5'd4, $urandom, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op(OP_LBU, 32'h0000_5001, $urandom, 5'd8, 32'h00A5_7F00, 1, 1'b1);
        run_op(OP_LH,  32'h0000_5002, $urandom, 5'd8, 32'h8001_7FFF, 3, 1'b1);
        run_op(OP_SW,  32'h0000_5004, $urandom, 5'd8, $urandom, 1, 1'b1);
        run_op(OP_LHU, 32'h0000_5002, $urandom, 5'd8, 32'h8001_7FFF, 2, 1'b1);
        idle_cycle();
    endtask

    task automatic test_random();
        logic [5:0] opTab[9];
        logic [4:0] rt;
        int ackAt, r;
        opTab = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH, 6'b001001};
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            ackAt = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 4);
            rt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_op(opTab[$urandom_range(0, 8)], $urandom, $urandom, rt, $urandom, ackAt,
                   ($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_lb_signed();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        test_noop_rt0();
        test_back_to_back();
        test_random();
        checkCount++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d loads never reported", exp_q.size());
        end else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning data-bus address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning WAIT cycles without bus_ack before a bus error is reported; minimum 1.
REQ-003 SHALL have clk  in  1  sole clock, rising edge.
REQ-004 SHALL have reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have valid  in  1  M-stage instruction valid.
REQ-006 SHALL have Instr_in  in  32  M-stage instruction word.
REQ-007 SHALL have MemAddr  in  ADDR_W  effective byte address.
REQ-008 SHALL have WriteData  in  32  store data, already forwarded.
REQ-009 SHALL have stall  out  1  freeze pipeline at and before M.
REQ-010 SHALL have bus_req, bus_we  out  1 each  request strobe; write qualifier.
REQ-011 SHALL have bus_addr  out  ADDR_W  word address; bits [1:0] always 0.
REQ-012 SHALL have bus_be  out  4  byte enables; bus_wdata  out  32  lane-replicated store data.
REQ-013 SHALL have bus_ack  in  1; bus_rdata  in  32.
REQ-014 SHALL have load_data  out  32; load_valid  out  1  one-cycle load result strobe.
REQ-015 SHALL have exc  out  1; exc_code  out  2  (0 none, 1 AdEL, 2 AdES, 3 bus timeout).

Function
REQ-016 SHALL decode opcodes lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sb 101000, sh 101001; every other opcode is a non-memory op.
REQ-017 SHALL treat a non-memory op, or valid=0, as a no-op: no bus_req, stall=0, exc=0.
REQ-018 SHALL flag misalignment when: word op with MemAddr[1:0]!=0; half op with MemAddr[0]!=0; byte ops are never misaligned.
REQ-019 SHALL, for a misaligned op in IDLE, issue no bus request, keep stall=0, and drive exc=1 with code 1 (load) or 2 (store) in the same cycle.
REQ-020 SHALL implement FSM IDLE, WAIT, DONE.
REQ-021 SHALL, in IDLE with an aligned memory op and valid=1: assert stall combinationally, register address, be, wdata and op, and go to WAIT.
REQ-022 SHALL, in WAIT, drive bus_req=1, with bus_addr, bus_be, bus_we and bus_wdata held stable from the registers; stall=1.
REQ-023 SHALL, in WAIT on bus_ack=1, capture the extended bus_rdata (loads) and go to DONE.
REQ-024 SHALL, in WAIT, count cycles; at TIMEOUT cycles without ack, go to DONE with a latched error.
REQ-025 SHALL give ack priority over timeout when both occur in the same cycle.
REQ-026 SHALL, in DONE, drive stall=0, load_valid=1 for loads without error, and exc=1 with code 3 on error; go to IDLE unconditionally.
REQ-027 SHALL NOT relaunch the DONE-cycle instruction.
REQ-028 SHALL size store byte enables as follows: sb 1<<MemAddr[1:0]; sh 0011 if MemAddr[1]=0, else 1100; sw 1111.
REQ-029 SHALL build bus_wdata as: sb {4{WriteData[7:0]}}, sh {2{WriteData[15:0]}}, sw WriteData; store data SHALL be 0 when Instr_in[20:16]==0.
REQ-030 SHALL extend loads little-endian, using byte lane k = bits 8k+7:8k: lb sign, lbu zero, lh/lhu half selected by MemAddr[1], lw unchanged.
REQ-031 SHALL keep load_data unchanged outside DONE; bus_ack outside WAIT is ignored.

Reset
REQ-032 SHALL, on reset, force IDLE, clear the counter, error flag and registers, and drive load_data=0 and all strobes, stall and exc to 0 on the next edge.
REQ-033 SHALL, on reset in WAIT, abandon the access: bus_req=0 next cycle, and a late ack SHALL produce no load_valid.

Verification
REQ-034 SHALL cover: lb at 0x1003, bus_rdata 0x80FF_FF00, ack after 2 cycles -> stall for 3 cycles, load_data 0xFFFF_FF80, load_valid for 1 cycle.
REQ-035 SHALL cover: sh at 0x2002, WriteData 0x1234_ABCD, rt=5 -> bus_be 1100, bus_wdata 0xABCD_ABCD, bus_addr 0x2000, bus_we=1.
REQ-036 SHALL cover: lw at 0x0006 -> no bus_req, stall=0, exc=1, exc_code=1 same cycle; sw at 0x0005 -> exc_code=2.
REQ-037 SHALL cover: lw with bus_ack never asserted, TIMEOUT=15 -> DONE after 15 WAIT cycles, exc_code=3, load_valid=0; ack on cycle 15 -> normal completion.
REQ-038 SHALL cover: reset asserted in WAIT cycle 2 -> bus_req=0 next cycle, and ack one cycle later produces no load_valid.
REQ-039 SHALL cover: sb with rt=0 -> bus_wdata 0; addu opcode 000000 with valid=1 -> no request, stall=0.
